// File: rtl/irq_controller_if.sv
// Register bus and CPU interrupt handshake
// bundled for the interrupt controller.
interface irq_controller_if #(
  parameter int N_SRC = 4
);
  logic             MemWrite;
  logic [1:0]       address;
  logic [31:0]      write_data;
  logic [31:0]      read_data;
  logic [N_SRC-1:0] irq_in;
  logic             irq_req;
  logic [2:0]       irq_id;
  logic             irq_ack;

  modport master (
    output MemWrite, address, write_data,
    output irq_in, irq_ack,
    input  read_data, irq_req, irq_id
  );

  modport slave (
    input  MemWrite, address, write_data,
    input  irq_in, irq_ack,
    output read_data, irq_req, irq_id
  );
endinterface

// File: rtl/irq_controller.sv
// Edge-latched, masked, fixed-priority interrupt
// controller with a single in-service slot and EOI.
module irq_controller #(
  parameter int N_SRC = 4
) (
  input logic              clk,
  input logic              reset,
  irq_controller_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SVC  = 2'd2;

  logic [1:0]       state;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] prev;
  logic             gen;
  logic             in_svc;
  logic [2:0]       svc_id;
  logic [2:0]       id_q;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] id_oh;
  logic [N_SRC-1:0] clr;
  logic [2:0]       sel;
  logic             wr_pend;
  logic             wr_mask;
  logic             wr_ctrl;
  logic             eoi;
  logic             ack;
  logic             hold;
  logic             any_act;
  logic             unused_wd;

  assign rise    = bus.irq_in & ~prev;
  assign active  = pending & mask;
  assign any_act = |active;
  assign wr_pend = bus.MemWrite
                 && bus.address == 2'd0;
  assign wr_mask = bus.MemWrite
                 && bus.address == 2'd1;
  assign wr_ctrl = bus.MemWrite
                 && bus.address == 2'd2;
  assign eoi     = wr_ctrl
                 && bus.write_data[31];
  assign ack     = state == REQ
                 && bus.irq_ack;
  assign unused_wd = ^bus.write_data;

  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (active[i]) sel = 3'(i);
  end

  always_comb begin
    id_oh = '0;
    for (int i = 0; i < N_SRC; i++)
      id_oh[i] = (id_q == 3'(i));
  end

  // Software W1C and ack clear combine; a new edge wins.
  assign clr =
    ({N_SRC{wr_pend}}
      & bus.write_data[N_SRC-1:0])
    | ({N_SRC{ack}} & id_oh);

  assign hold = gen && |(id_oh & active);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      mask    <= '0;
      prev    <= '0;
      gen     <= 1'b0;
      in_svc  <= 1'b0;
      svc_id  <= '0;
      id_q    <= '0;
    end else begin
      prev    <= bus.irq_in;
      pending <= (pending & ~clr) | rise;
      if (wr_mask)
        mask <= bus.write_data[N_SRC-1:0];
      if (wr_ctrl)
        gen <= bus.write_data[0];
      unique case (state)
        IDLE: begin
          if (gen && any_act) begin
            state <= REQ;
            id_q  <= sel;
          end
        end
        REQ: begin
          if (ack) begin
            state  <= SVC;
            in_svc <= 1'b1;
            svc_id <= id_q;
          end else if (!hold) begin
            state <= IDLE;
          end
        end
        SVC: begin
          if (eoi) begin
            state  <= IDLE;
            in_svc <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.irq_req = state == REQ;
  assign bus.irq_id  = id_q;

  always_comb begin
    bus.read_data = '0;
    unique case (bus.address)
      2'd0: bus.read_data = 32'(pending);
      2'd1: bus.read_data = 32'(mask);
      2'd2: bus.read_data =
        {25'b0, svc_id, 2'b0, in_svc, gen};
      2'd3: bus.read_data =
        {23'b0, any_act, 1'b0, id_q,
         3'b0, bus.irq_req};
      default: bus.read_data = '0;
    endcase
  end
endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for the
// interrupt controller.
module tb_irq_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] d;

  irq_controller_if #(.N_SRC(4)) bus ();

  irq_controller #(.N_SRC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] v);
    bus.MemWrite   = 1'b1;
    bus.address    = a;
    bus.write_data = v;
    step();
    bus.MemWrite   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [31:0] v);
    bus.address = a;
    #1;
    v = bus.read_data;
  endtask

  task automatic ack_pulse();
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h want=0",
                 a, d);
      end
    end
    checks++;
    if (bus.irq_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got=%b want=0",
               bus.irq_req);
    end
  endtask

  task automatic test_basic();
    wr(2'd1, 32'h1);
    wr(2'd2, 32'h1);
    bus.irq_in = 4'b0001;
    step();
    rd(2'd0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL basic_pend got=%h want=1", d);
    end
    step();
    bus.irq_in = 4'b0000;
    checks++;
    if (bus.irq_req !== 1'b1
        || bus.irq_id !== 3'd0) begin
      errors++;
      $display("FAIL basic_req got=%b/%0d want=1/0",
               bus.irq_req, bus.irq_id);
    end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h101) begin
      errors++;
      $display("FAIL basic_stat got=%h want=101", d);
    end
    ack_pulse();
    rd(2'd0, d);
    checks++;
    if (bus.irq_req !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL basic_ack got=%b/%h want=0/0",
               bus.irq_req, d);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h3) begin
      errors++;
      $display("FAIL basic_ctrl_svc got=%h want=3", d);
    end
    wr(2'd2, 32'h8000_0001);
    rd(2'd2, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL basic_eoi got=%h want=1", d);
    end
  endtask

  task automatic test_priority();
    wr(2'd1, 32'hF);
    bus.irq_in = 4'b1100;
    step();
    step();
    checks++;
    if (bus.irq_req !== 1'b1
        || bus.irq_id !== 3'd2) begin
      errors++;
      $display("FAIL prio_first got=%b/%0d want=1/2",
               bus.irq_req, bus.irq_id);
    end
    bus.irq_in = 4'b1101;
    step();
    step();
    checks++;
    if (bus.irq_req !== 1'b1
        || bus.irq_id !== 3'd2) begin
      errors++;
      $display("FAIL prio_latch got=%b/%0d want=1/2",
               bus.irq_req, bus.irq_id);
    end
    ack_pulse();
    rd(2'd0, d);
    checks++;
    if (d !== 32'h9) begin
      errors++;
      $display("FAIL prio_pend got=%h want=9", d);
    end
    wr(2'd2, 32'h8000_0001);
    step();
    checks++;
    if (bus.irq_req !== 1'b1
        || bus.irq_id !== 3'd0) begin
      errors++;
      $display("FAIL prio_second got=%b/%0d want=1/0",
               bus.irq_req, bus.irq_id);
    end
    ack_pulse();
    wr(2'd2, 32'h8000_0001);
    step();
    checks++;
    if (bus.irq_req !== 1'b1
        || bus.irq_id !== 3'd3) begin
      errors++;
      $display("FAIL prio_third got=%b/%0d want=1/3",
               bus.irq_req, bus.irq_id);
    end
    ack_pulse();
    wr(2'd2, 32'h8000_0001);
    bus.irq_in = 4'b0000;
    step();
    step();
  endtask

  task automatic test_withdraw();
    bus.irq_in = 4'b0010;
    step();
    step();
    checks++;
    if (bus.irq_req !== 1'b1
        || bus.irq_id !== 3'd1) begin
      errors++;
      $display("FAIL wd_req got=%b/%0d want=1/1",
               bus.irq_req, bus.irq_id);
    end
    wr(2'd1, 32'hD);
    step();
    rd(2'd3, d);
    checks++;
    if (bus.irq_req !== 1'b0 || d !== 32'h010) begin
      errors++;
      $display("FAIL wd_drop got=%b/%h want=0/010",
               bus.irq_req, d);
    end
    wr(2'd1, 32'hF);
    step();
    checks++;
    if (bus.irq_req !== 1'b1
        || bus.irq_id !== 3'd1) begin
      errors++;
      $display("FAIL wd_again got=%b/%0d want=1/1",
               bus.irq_req, bus.irq_id);
    end
    ack_pulse();
    wr(2'd2, 32'h8000_0001);
    bus.irq_in = 4'b0000;
    step();
  endtask

  task automatic test_level();
    bus.irq_in = 4'b0001;
    step();
    step();
    ack_pulse();
    wr(2'd2, 32'h8000_0001);
    step();
    step();
    step();
    rd(2'd0, d);
    checks++;
    if (bus.irq_req !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL level_hold got=%b/%h want=0/0",
               bus.irq_req, d);
    end
    bus.irq_in = 4'b0000;
    step();
    bus.irq_in = 4'b0001;
    step();
    step();
    checks++;
    if (bus.irq_req !== 1'b1
        || bus.irq_id !== 3'd0) begin
      errors++;
      $display("FAIL level_retrig got=%b/%0d want=1/0",
               bus.irq_req, bus.irq_id);
    end
    ack_pulse();
    wr(2'd2, 32'h8000_0001);
    bus.irq_in = 4'b0000;
    step();
  endtask

  task automatic test_back_to_back();
    bus.irq_in = 4'b0001;
    wr(2'd0, 32'h1);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL b2b_setwins got=%h want=1", d);
    end
    step();
    checks++;
    if (bus.irq_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_req got=%b want=1",
               bus.irq_req);
    end
    bus.irq_ack = 1'b1;
    wr(2'd2, 32'h8000_0001);
    bus.irq_ack = 1'b0;
    rd(2'd2, d);
    checks++;
    if (bus.irq_req !== 1'b0 || d !== 32'h3) begin
      errors++;
      $display("FAIL b2b_ackeoi got=%b/%h want=0/3",
               bus.irq_req, d);
    end
    wr(2'd2, 32'h8000_0001);
    bus.irq_in = 4'b0000;
    step();
    bus.irq_in = 4'b0011;
    step();
    step();
    bus.irq_ack = 1'b1;
    wr(2'd0, 32'h2);
    bus.irq_ack = 1'b0;
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL b2b_orclr got=%h want=0", d);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h3) begin
      errors++;
      $display("FAIL b2b_svc got=%h want=3", d);
    end
    wr(2'd2, 32'h8000_0001);
    step();
    checks++;
    if (bus.irq_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got=%b want=0",
               bus.irq_req);
    end
    bus.irq_in = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid();
    bus.irq_in = 4'b0101;
    step();
    step();
    ack_pulse();
    reset = 1'b1;
    step();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL rmid_reg%0d got=%h want=0",
                 a, d);
      end
    end
    checks++;
    if (bus.irq_req !== 1'b0) begin
      errors++;
      $display("FAIL rmid_req got=%b want=0",
               bus.irq_req);
    end
    reset = 1'b0;
    step();
    rd(2'd0, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL rmid_relatch got=%h want=5", d);
    end
  endtask

  initial begin
    bus.MemWrite   = 1'b0;
    bus.address    = 2'd0;
    bus.write_data = '0;
    bus.irq_in     = '0;
    bus.irq_ack    = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_withdraw();
    test_level();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
